ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Micro-op sequencer for ARM block transfers (LDM/STM).
- Takes one decoded LDM/STM from Decode, walks its 16-bit register list and issues one word transfer per cycle (register number, address, direction) into the shared ALU/memory path.
- Then issues an optional base-register writeback.
- Holds Decode with a stall while the sequence runs.

Parameters:
- NREGS, 16, width of register list / register-file entries addressed (fixed at 16 for ARM).
- WORDBYTES, 4, address increment per transfer.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- StartD  in  1  Decode holds a valid LDM/STM and is not flushed; sampled only in IDLE.
- InstrD  in  32  instruction: [24]=P, [23]=U, [21]=W, [20]=L, [19:16]=Rn, [15:0]=register list.
- BaseD  in  32  current value of Rn, valid when StartD=1.
- StallSeq  in  1  hazard-unit stall; freezes all sequencer state and outputs.
- uOpStallD  out  1  holds Decode/Fetch while a sequence is pending.
- XferValid  out  1  transfer issued this cycle.
- XferReg  out  4  register for this transfer.
- XferAddr  out  32  word address for this transfer.
- XferLoad  out  1  1=load (LDM), 0=store (STM).
- XferLast  out  1  final transfer of the list.
- PCLoaded  out  1  pulses with the transfer of R15 when L=1 (redirect request).
- WbValid  out  1  base writeback issued this cycle.
- WbReg  out  4  = captured Rn.
- WbValue  out  32  updated base.
- EmptyList  out  1  one-cycle pulse: StartD accepted with list==0.

Behaviour:
- Reset: state IDLE. All outputs 0, captured registers 0. Takes effect immediately and asynchronously, including mid-sequence; any partial sequence is abandoned with no further transfers.
- States: IDLE, XFER, WB.
- Start acceptance: IDLE with StartD=1 and StallSeq=0 accepts the instruction.
- Captured at acceptance: L, W, U, Rn, list, N = popcount(list) (5 bits, 0..16).
- Start address A0 (mod 2^32 wrap):
  - IA (P=0,U=1): Base
  - IB (P=1,U=1): Base+4
  - DA (P=0,U=0): Base-4N+4
  - DB (P=1,U=0): Base-4N
- Transfer order: always ascending register number, ascending address, regardless of U.
- Writeback value: U ? Base+4N : Base-4N.
- uOpStallD (combinational): StartD in IDLE with list≠0, OR (state≠IDLE AND NOT final output cycle).
  - Final output cycle = last transfer when no writeback is pending; otherwise the WB cycle.
- Transition from IDLE: next state XFER if list≠0, else stays IDLE.
  - list==0: no transfer, no writeback, EmptyList=1 for the acceptance cycle, uOpStallD=0.
- XFER, each non-stalled cycle:
  - XferValid=1.
  - XferReg = index of lowest set bit of the remaining mask.
  - XferAddr = running address.
  - On clock edge: clear that bit; address += 4.
  - XferLast=1 when exactly one bit remains.
  - After the last transfer: go to WB if W=1 and NOT (L=1 and Rn in list); else IDLE.
- WB: one cycle, WbValid=1, then IDLE.
- STM with Rn in list and W=1: writeback still performed. The stored Rn value is the original base; data sourcing is the datapath's job.
- PCLoaded=1 exactly in the cycle XferReg==15 and L=1. Because 15 is highest, it is always the last transfer.
- StallSeq=1: state, mask, address and all outputs hold their previous values. A held transfer is not counted twice.
- StartD while state≠IDLE: ignored (Decode is stalled; bench asserts it never occurs).
- Latency: N transfer cycles + 1 WB cycle (if writeback) after acceptance, plus stall cycles.

Test Plan:
- STMIA R0!,{R1,R2,R4,R7}, Base=0x1000 -> transfers R1@0x1000, R2@0x1004, R4@0x1008, R7@0x100C (XferLast on R7), then WbValue=0x1010, WbReg=0; uOpStallD high 5 cycles.
- LDMDB R3!,{R0,R5}, Base=0x200 -> R0@0x1F8, R5@0x1FC, then WbValue=0x1F8; XferLoad=1 throughout.
- LDMIA R2!,{R1,R2,R15}, Base=0x40 -> three transfers, PCLoaded=1 only with R15@0x48, no WbValid (Rn in list).
- LDMIB R1,{R4,R6}, Base=0xFFFFFFF8 -> R4@0xFFFFFFFC, R6@0x00000000 (wrap), no writeback.
- STMDA R0,{R2,R3,R9} with StallSeq high 3 cycles on 2nd transfer -> R3@Base-4 held 4 cycles, no duplicate or skip; sequence completes normally.
- StartD with list=0 -> EmptyList pulse, no XferValid/WbValid, uOpStallD=0. Separately: reset low mid-XFER -> all outputs 0 asynchronously, IDLE after release, next StartD accepted.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: expands one decoded ARM LDM/STM into a stream of
// single-word transfers (ascending register / ascending address), followed
// by an optional base-register writeback, while stalling Decode.
module ldm_stm_sequencer #(
   parameter int NREGS     = 16,
   parameter int WORDBYTES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StartD,
   input  logic [31:0] InstrD,
   input  logic [31:0] BaseD,
   input  logic        StallSeq,
   output logic        uOpStallD,
   output logic        XferValid,
   output logic [3:0]  XferReg,
   output logic [31:0] XferAddr,
   output logic        XferLoad,
   output logic        XferLast,
   output logic        PCLoaded,
   output logic        WbValid,
   output logic [3:0]  WbReg,
   output logic [31:0] WbValue,
   output logic        EmptyList
);

   typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

   state_t             state, next_state;
   logic [NREGS-1:0]   mask;
   logic [31:0]        addr;
   logic               load_q;
   logic               wb_pend;
   logic [3:0]         rn_q;
   logic [31:0]        wb_val;

   logic [NREGS-1:0]   new_list;
   logic [4:0]         new_cnt;
   logic [31:0]        span;
   logic [31:0]        start_addr;
   logic [3:0]         low_idx;
   logic [NREGS-1:0]   mask_next;
   logic               last_xfer;
   logic               accept;
   logic               bit_p, bit_u, bit_w, bit_l;
   logic [3:0]         new_rn;

   assign new_list  = InstrD[NREGS-1:0];
   assign bit_p     = InstrD[24];
   assign bit_u     = InstrD[23];
   assign bit_w     = InstrD[21];
   assign bit_l     = InstrD[20];
   assign new_rn    = InstrD[19:16];
   assign accept    = (state == IDLE) && StartD && !StallSeq;
   // Clearing the lowest set bit is mask & (mask-1); it also tells us when one bit remains.
   assign mask_next = mask & (mask - {{(NREGS-1){1'b0}}, 1'b1});
   assign last_xfer = (mask_next == '0);
   assign span      = 32'(new_cnt) * 32'(WORDBYTES);

   // Population count of the incoming register list.
   always_comb begin
      new_cnt = '0;
      for (int i = 0; i < NREGS; i++)
         new_cnt = new_cnt + 5'(new_list[i]);
   end

   // Index of the lowest register still to be transferred.
   always_comb begin
      low_idx = '0;
      for (int i = NREGS - 1; i >= 0; i--)
         if (mask[i]) low_idx = 4'(i);
   end

   // First address of the block; transfers always walk upward from here.
   always_comb begin
      case ({bit_p, bit_u})
         2'b01:   start_addr = BaseD;
         2'b11:   start_addr = BaseD + 32'(WORDBYTES);
         2'b00:   start_addr = BaseD - span + 32'(WORDBYTES);
         default: start_addr = BaseD - span;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Captured instruction fields, remaining mask and running address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask    <= '0;
         addr    <= '0;
         load_q  <= 1'b0;
         wb_pend <= 1'b0;
         rn_q    <= '0;
         wb_val  <= '0;
      end else if (accept) begin
         mask    <= new_list;
         addr    <= start_addr;
         load_q  <= bit_l;
         wb_pend <= bit_w && !(bit_l && new_list[new_rn]);
         rn_q    <= new_rn;
         wb_val  <= bit_u ? (BaseD + span) : (BaseD - span);
      end else if (state == XFER && !StallSeq) begin
         mask <= mask_next;
         addr <= addr + 32'(WORDBYTES);
      end
   end

   // Next-state logic; a stall freezes the current state.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept && new_list != '0) next_state = XFER;
         XFER: if (!StallSeq && last_xfer)   next_state = wb_pend ? WB : IDLE;
         WB:   if (!StallSeq)                next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs decoded from the registered state, forced low while in reset.
   always_comb begin
      uOpStallD = 1'b0;
      XferValid = 1'b0;
      XferReg   = '0;
      XferAddr  = '0;
      XferLoad  = 1'b0;
      XferLast  = 1'b0;
      PCLoaded  = 1'b0;
      WbValid   = 1'b0;
      WbReg     = '0;
      WbValue   = '0;
      EmptyList = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               uOpStallD = StartD && (new_list != '0);
               EmptyList = accept && (new_list == '0);
            end
            XFER: begin
               XferValid = 1'b1;
               XferReg   = low_idx;
               XferAddr  = addr;
               XferLoad  = load_q;
               XferLast  = last_xfer;
               PCLoaded  = load_q && (low_idx == 4'(NREGS - 1));
               uOpStallD = !(last_xfer && !wb_pend);
            end
            WB: begin
               WbValid = 1'b1;
               WbReg   = rn_q;
               WbValue = wb_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: scoreboard bench. Expected transfers/writebacks are
// queued when an instruction is launched and consumed as the DUT issues them.
module tb_ldm_stm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        StartD;
   logic [31:0] InstrD;
   logic [31:0] BaseD;
   logic        StallSeq;
   logic        uOpStallD, XferValid, XferLoad, XferLast, PCLoaded, WbValid, EmptyList;
   logic [3:0]  XferReg, WbReg;
   logic [31:0] XferAddr, WbValue;

   typedef struct {
      logic        isWb;
      logic [3:0]  rg;
      logic [31:0] val;
      logic        load;
      logic        last;
      logic        pcl;
   } exp_t;

   exp_t        expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          stallCnt = 0;
   int          heldCnt = 0;
   int          emptyCnt = 0;
   logic [31:0] lastXferAddr = '0;
   logic [31:0] lastWbValue = '0;

   ldm_stm_sequencer #(.NREGS(16), .WORDBYTES(4)) dut (
      .clk(clk), .reset(reset), .StartD(StartD), .InstrD(InstrD), .BaseD(BaseD),
      .StallSeq(StallSeq), .uOpStallD(uOpStallD), .XferValid(XferValid),
      .XferReg(XferReg), .XferAddr(XferAddr), .XferLoad(XferLoad),
      .XferLast(XferLast), .PCLoaded(PCLoaded), .WbValid(WbValid),
      .WbReg(WbReg), .WbValue(WbValue), .EmptyList(EmptyList)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mkInstr(input logic p, input logic u, input logic w,
                                           input logic l, input logic [3:0] rn,
                                           input logic [15:0] list);
      return {7'b1110100, p, u, 1'b0, w, l, rn, list};
   endfunction

   // Reference model: pushes the transfers and writeback an instruction should produce.
   task automatic pushExpected(input logic [31:0] instr, input logic [31:0] base,
                               output int nXfer, output bit hasWb);
      logic        p, u, w, l;
      logic [3:0]  rn;
      logic [15:0] list;
      logic [31:0] a;
      exp_t        e;
      int          k;
      p = instr[24]; u = instr[23]; w = instr[21]; l = instr[20];
      rn = instr[19:16]; list = instr[15:0];
      nXfer = 0;
      for (int i = 0; i < 16; i++) if (list[i]) nXfer++;
      hasWb = 0;
      if (nXfer == 0) return;
      if (u) a = p ? base + 4 : base;
      else   a = p ? base - 32'(4 * nXfer) : base - 32'(4 * nXfer) + 4;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            e.isWb = 0; e.rg = 4'(i); e.val = a; e.load = l;
            e.last = (k == nXfer - 1); e.pcl = l && (i == 15);
            expQ.push_back(e);
            a = a + 4;
            k++;
         end
      end
      if (w && !(l && list[rn])) begin
         hasWb = 1;
         e.isWb = 1; e.rg = rn; e.load = 0; e.last = 0; e.pcl = 0;
         e.val = u ? base + 32'(4 * nXfer) : base - 32'(4 * nXfer);
         expQ.push_back(e);
      end
   endtask

   // Launch one instruction, optionally stall on a given transfer, and check completion.
   task automatic applyStimulus(input string name, input logic [31:0] instr,
                                input logic [31:0] base, input int stallAt, input int stallLen);
      int nXfer;
      bit hasWb;
      int expStall;
      pushExpected(instr, base, nXfer, hasWb);
      stallCnt = 0; heldCnt = 0; emptyCnt = 0;
      @(posedge clk); #1;
      InstrD = instr; BaseD = base; StartD = 1'b1;
      @(negedge clk);
      checkOutput({name, "_accept_stall"}, 32'(uOpStallD), 32'(nXfer != 0));
      checkOutput({name, "_accept_empty"}, 32'(EmptyList), 32'(nXfer == 0));
      @(posedge clk); #1;
      StartD = 1'b0; BaseD = $urandom;
      if (stallAt > 0) begin
         repeat (stallAt - 1) @(posedge clk);
         #1 StallSeq = 1'b1;
         repeat (stallLen) @(posedge clk);
         #1 StallSeq = 1'b0;
      end
      for (int c = 0; c < 64 && expQ.size() != 0; c++) @(posedge clk);
      checkOutput({name, "_done"}, 32'(expQ.size()), 0);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      expStall = (nXfer == 0) ? 0 : (hasWb ? 1 + nXfer : nXfer) + stallLen;
      checkOutput({name, "_stall_cycles"}, 32'(stallCnt), 32'(expStall));
      checkOutput({name, "_held_cycles"}, 32'(heldCnt), 32'(stallLen));
      checkOutput({name, "_empty_pulses"}, 32'(emptyCnt), 32'(nXfer == 0));
   endtask

   // Monitor: compares every issued transfer/writeback with the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (uOpStallD) stallCnt++;
         if (EmptyList) emptyCnt++;
         if (XferValid || WbValid) begin
            checkOutput("issue_expected", 32'(expQ.size() != 0), 1);
            checkOutput("one_issue_only", 32'(XferValid && WbValid), 0);
            if (expQ.size() != 0) begin
               e = expQ[0];
               checkOutput("kind_is_wb", 32'(WbValid), 32'(e.isWb));
               if (XferValid) begin
                  checkOutput("xfer_reg", 32'(XferReg), 32'(e.rg));
                  checkOutput("xfer_addr", XferAddr, e.val);
                  checkOutput("xfer_load", 32'(XferLoad), 32'(e.load));
                  checkOutput("xfer_last", 32'(XferLast), 32'(e.last));
                  checkOutput("pc_loaded", 32'(PCLoaded), 32'(e.pcl));
               end else begin
                  checkOutput("wb_reg", 32'(WbReg), 32'(e.rg));
                  checkOutput("wb_value", WbValue, e.val);
               end
               if (StallSeq) heldCnt++;
               else begin
                  if (XferValid) lastXferAddr = XferAddr;
                  else           lastWbValue = WbValue;
                  void'(expQ.pop_front());
               end
            end
         end else if (!StallSeq) begin
            checkOutput("pc_loaded_idle", 32'(PCLoaded), 0);
         end
      end
   end

   initial begin
      int          nX;
      bit          hw;
      logic [31:0] ri;
      reset = 1'b0; StartD = 1'b0; InstrD = '0; BaseD = '0; StallSeq = 1'b0;
      #1;
      checkOutput("reset_xfer_valid", 32'(XferValid), 0);
      checkOutput("reset_wb_valid", 32'(WbValid), 0);
      checkOutput("reset_stall", 32'(uOpStallD), 0);
      checkOutput("reset_addr", XferAddr, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      applyStimulus("stmia", mkInstr(0, 1, 1, 0, 4'd0, 16'h0096), 32'h0000_1000, 0, 0);
      checkOutput("stmia_wb_value", lastWbValue, 32'h0000_1010);
      applyStimulus("ldmdb", mkInstr(1, 0, 1, 1, 4'd3, 16'h0021), 32'h0000_0200, 0, 0);
      checkOutput("ldmdb_wb_value", lastWbValue, 32'h0000_01F8);
      applyStimulus("ldmia_pc", mkInstr(0, 1, 1, 1, 4'd2, 16'h8006), 32'h0000_0040, 0, 0);
      checkOutput("ldmia_pc_addr", lastXferAddr, 32'h0000_0048);
      applyStimulus("ldmib_wrap", mkInstr(1, 1, 0, 1, 4'd1, 16'h0050), 32'hFFFF_FFF8, 0, 0);
      checkOutput("ldmib_wrap_addr", lastXferAddr, 32'h0000_0000);
      applyStimulus("stmda_stall", mkInstr(0, 0, 0, 0, 4'd0, 16'h020C), 32'h0000_3000, 2, 3);
      checkOutput("stmda_last_addr", lastXferAddr, 32'h0000_3000);
      applyStimulus("empty", mkInstr(0, 1, 1, 1, 4'd4, 16'h0000), 32'h0000_0700, 0, 0);
      applyStimulus("stm_rn_in_list", mkInstr(0, 1, 1, 0, 4'd1, 16'h0006), 32'h0000_0900, 0, 0);

      // Reset mid-sequence: abandon an eight-register load after two transfers.
      ri = mkInstr(0, 1, 1, 1, 4'd6, 16'h00FF);
      pushExpected(ri, 32'h0000_0500, nX, hw);
      @(posedge clk); #1;
      InstrD = ri; BaseD = 32'h0000_0500; StartD = 1'b1;
      @(posedge clk); #1;
      StartD = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      checkOutput("midrst_xfer_valid", 32'(XferValid), 0);
      checkOutput("midrst_xfer_reg", 32'(XferReg), 0);
      checkOutput("midrst_xfer_addr", XferAddr, 0);
      checkOutput("midrst_stall", 32'(uOpStallD), 0);
      checkOutput("midrst_load", 32'(XferLoad), 0);
      checkOutput("midrst_consumed", 32'(expQ.size()), 32'(nX + (hw ? 1 : 0) - 2));
      expQ.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("postrst_idle", 32'(XferValid || WbValid || uOpStallD), 0);
      applyStimulus("after_reset", mkInstr(0, 1, 1, 0, 4'd5, 16'h000F), 32'h0000_0080, 0, 0);

      for (int t = 0; t < 4; t++)
         applyStimulus("random", mkInstr(1'($urandom), 1'($urandom), 1'($urandom),
                                         1'($urandom), 4'($urandom), 16'($urandom)),
                       $urandom, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
